wb_initiator: RTL and testbench

- Single-outstanding Wishbone classic initiator that drives the accelerator's Wishbone slave port (cyc/stb/we/sel/addr/data → ack/data).
- Accepts one read or write command on a valid/ready command channel and runs exactly one bus cycle for it.
- Returns read data plus an error flag on a valid/ready response channel.
- Bus cycles that see no ack within a programmable window are aborted as errors, so an unresponsive slave cannot hang the requester.

---
 rtl/accel_bus_pkg.sv | 23 ++
 rtl/wb_initiator_if.sv | 49 ++++
 rtl/wb_initiator.sv | 136 +++++++++++++
 tb/tb_wb_initiator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_bus_pkg.sv
// ============================================================================
// accel_bus_pkg : shared constants for the accelerator Wishbone initiator
// Rev 1.0
// ============================================================================
`default_nettype none

package accel_bus_pkg;

    localparam int ACCEL_ADDR_W = 28;
    localparam int ACCEL_DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUS  = 2'd1;
    localparam state_t RESP = 2'd2;

    // Bit index of the timeout flag inside a future multi-bit error code.
    localparam int RSP_ERR_TIMEOUT = 0;

endpackage

`default_nettype wire

// File: rtl/wb_initiator_if.sv
// ============================================================================
// wb_initiator_if : command/response channels plus Wishbone classic bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_initiator_if #(
    parameter int ADDR_W = accel_bus_pkg::ACCEL_ADDR_W,
    parameter int DATA_W = accel_bus_pkg::ACCEL_DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_sel;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;

    // master: the initiator itself; slave: requester plus Wishbone target side
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
               wb_dat_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
               wb_dat_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_initiator.sv
// ============================================================================
// wb_initiator : single-outstanding Wishbone classic initiator with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_initiator #(
    parameter int ADDR_W  = accel_bus_pkg::ACCEL_ADDR_W,
    parameter int DATA_W  = accel_bus_pkg::ACCEL_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    wb_initiator_if.master  bus
);
    import accel_bus_pkg::*;

    localparam int                SEL_W      = DATA_W / 8;
    localparam logic [CNT_W-1:0]  c_cnt_max  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_cnt_last = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_cyc, w_cyc;
    logic                r_stb, w_stb;
    logic                r_we, w_we;
    logic [SEL_W-1:0]    r_sel, w_sel;
    logic [ADDR_W-1:0]   r_adr, w_adr;
    logic [DATA_W-1:0]   r_dat, w_dat;
    logic                r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic                r_rsp_err, w_rsp_err;
    logic                w_timeout;

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cyc       <= w_cyc;
            r_stb       <= w_stb;
            r_we        <= w_we;
            r_sel       <= w_sel;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    always_comb begin
        w_state = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_valid) w_state = BUS;
            BUS:     if (bus.wb_ack_i || w_timeout) w_state = RESP;
            RESP:    if (r_rsp_valid && bus.rsp_ready) w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    // Next values of every registered output; ack takes priority over timeout.
    always_comb begin
        w_cnt       = r_cnt;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_we        = r_we;
        w_sel       = r_sel;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_cyc = 1'b1;
                    w_stb = 1'b1;
                    w_we  = bus.cmd_we;
                    w_sel = bus.cmd_sel;
                    w_adr = bus.cmd_addr;
                    w_dat = bus.cmd_wdata;
                    w_cnt = '0;
                end
            end
            BUS: begin
                if (r_cnt != c_cnt_max) w_cnt = r_cnt + CNT_W'(1);
                if (bus.wb_ack_i) begin
                    w_cyc       = 1'b0;
                    w_stb       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b0;
                    w_rsp_rdata = r_we ? '0 : bus.wb_dat_i;
                end else if (w_timeout) begin
                    w_cyc       = 1'b0;
                    w_stb       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_rdata = '0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) w_rsp_valid = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.wb_cyc_o  = r_cyc;
    assign bus.wb_stb_o  = r_stb;
    assign bus.wb_we_o   = r_we;
    assign bus.wb_sel_o  = r_sel;
    assign bus.wb_adr_o  = r_adr;
    assign bus.wb_dat_o  = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_wb_initiator.sv
// ============================================================================
// tb_wb_initiator : scoreboard bench for wb_initiator (TIMEOUT 8 and 4 builds)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_initiator;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    // values captured by bus_slave8 while cyc is high
    int          cyc_n;
    bit          fields_stable;
    bit          slave_to;
    bit          early_rsp;
    logic        cap_we;
    logic [27:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_stb;

    wb_initiator_if #(.ADDR_W(28), .DATA_W(32)) if8 ();
    wb_initiator_if #(.ADDR_W(28), .DATA_W(32)) if4 ();

    wb_initiator #(.ADDR_W(28), .DATA_W(32), .TIMEOUT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    wb_initiator #(.ADDR_W(28), .DATA_W(32), .TIMEOUT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue8(input logic we, input logic [27:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input bit push,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        if8.cmd_we    = we;
        if8.cmd_addr  = addr;
        if8.cmd_wdata = wdata;
        if8.cmd_sel   = sel;
        if8.cmd_valid = 1'b1;
        @(negedge clk);
        if8.cmd_valid = 1'b0;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
        end
    endtask

    // Acks in bus cycle ack_at (0 = never); returns at the negedge where cyc first reads low.
    task automatic bus_slave8(input int ack_at, input logic [31:0] data);
        cyc_n = 0; fields_stable = 1'b1; slave_to = 1'b1; early_rsp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if8.wb_ack_i = 1'b0;
            if (!if8.wb_cyc_o) begin
                slave_to = 1'b0;
                break;
            end
            cyc_n++;
            if (if8.rsp_valid) early_rsp = 1'b1;
            if (cyc_n == 1) begin
                cap_we = if8.wb_we_o; cap_adr = if8.wb_adr_o;
                cap_dat = if8.wb_dat_o; cap_sel = if8.wb_sel_o; cap_stb = if8.wb_stb_o;
            end else if (cap_we !== if8.wb_we_o || cap_adr !== if8.wb_adr_o ||
                         cap_dat !== if8.wb_dat_o || cap_sel !== if8.wb_sel_o ||
                         if8.wb_stb_o !== 1'b1) begin
                fields_stable = 1'b0;
            end
            if (cyc_n == ack_at) begin
                if8.wb_ack_i = 1'b1;
                if8.wb_dat_i = data;
            end
        end
    endtask

    task automatic take_rsp8(output logic [31:0] rdata, output logic err, output bit got);
        got = 1'b0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if8.rsp_valid) begin
                got = 1'b1; rdata = if8.rsp_rdata; err = if8.rsp_err;
                break;
            end
            @(negedge clk);
        end
        if8.rsp_ready = 1'b1;
        @(negedge clk);
        if8.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (if8.wb_cyc_o !== 1'b0 || if8.wb_stb_o !== 1'b0 || if8.wb_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: cyc/stb/we=%b%b%b required 000", if8.wb_cyc_o, if8.wb_stb_o, if8.wb_we_o); end
        checks++; if (if8.wb_sel_o !== 4'h0 || if8.wb_adr_o !== 28'h0 || if8.wb_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_fields: sel=%h adr=%h dat=%h required 0", if8.wb_sel_o, if8.wb_adr_o, if8.wb_dat_o); end
        checks++; if (if8.rsp_valid !== 1'b0 || if8.rsp_rdata !== 32'h0 || if8.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: valid=%b rdata=%h err=%b required 0", if8.rsp_valid, if8.rsp_rdata, if8.rsp_err); end
        checks++; if (if8.cmd_ready !== 1'b1 || if4.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b/%b required 1/1", if8.cmd_ready, if4.cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait;
        exp_t e; logic [31:0] rd; logic er; bit got;
        issue8(1'b1, 28'h0000010, 32'hA5A5_0001, 4'hF, 1'b1, 32'h0, 1'b0);
        bus_slave8(1, 32'hFFFF_FFFF);
        checks++; if (slave_to || cyc_n != 1) begin
            errors++; $display("FAIL wr_cyc_len: cyc cycles=%0d required 1", cyc_n); end
        checks++; if (cap_we !== 1'b1 || cap_adr !== 28'h0000010 || cap_dat !== 32'hA5A5_0001 ||
                      cap_sel !== 4'hF || cap_stb !== 1'b1) begin
            errors++; $display("FAIL wr_fields: we=%b adr=%h dat=%h sel=%h stb=%b required 1 0000010 a5a50001 f 1",
                               cap_we, cap_adr, cap_dat, cap_sel, cap_stb); end
        checks++; if (if8.rsp_valid !== 1'b1 || early_rsp) begin
            errors++; $display("FAIL wr_latency: rsp_valid=%b early=%b required 1 at accept+2", if8.rsp_valid, early_rsp); end
        take_rsp8(rd, er, got);
        e = sb.pop_front();
        checks++; if (!got || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL wr_rsp: got=%b rdata=%h err=%b required rdata=%h err=%b", got, rd, er, e.rdata, e.err); end
    endtask

    task automatic test_read_wait3;
        exp_t e; logic [31:0] rd; logic er; bit got;
        issue8(1'b0, 28'h0000020, 32'h0000_0000, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0);
        bus_slave8(4, 32'hDEAD_BEEF);
        checks++; if (slave_to || cyc_n != 4 || !fields_stable) begin
            errors++; $display("FAIL rd_cyc_len: cyc cycles=%0d stable=%b required 4 1", cyc_n, fields_stable); end
        checks++; if (cap_we !== 1'b0 || cap_adr !== 28'h0000020) begin
            errors++; $display("FAIL rd_fields: we=%b adr=%h required 0 0000020", cap_we, cap_adr); end
        take_rsp8(rd, er, got);
        e = sb.pop_front();
        checks++; if (!got || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL rd_rsp: got=%b rdata=%h err=%b required rdata=%h err=%b", got, rd, er, e.rdata, e.err); end
    endtask

    task automatic test_timeout;
        exp_t e; logic [31:0] rd; logic er; bit got;
        if8.wb_dat_i = 32'h5555_AAAA;
        issue8(1'b0, 28'h0000024, 32'h0, 4'h3, 1'b1, 32'h0, 1'b1);
        bus_slave8(0, 32'h5555_AAAA);
        checks++; if (slave_to || cyc_n != 8 || !fields_stable) begin
            errors++; $display("FAIL to_cyc_len: cyc cycles=%0d stable=%b required 8 1", cyc_n, fields_stable); end
        take_rsp8(rd, er, got);
        e = sb.pop_front();
        checks++; if (!got || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL to_rsp: got=%b rdata=%h err=%b required rdata=%h err=%b", got, rd, er, e.rdata, e.err); end
        issue8(1'b0, 28'h0000028, 32'h0, 4'hF, 1'b1, 32'h0BAD_F00D, 1'b0);
        bus_slave8(2, 32'h0BAD_F00D);
        take_rsp8(rd, er, got);
        e = sb.pop_front();
        checks++; if (cyc_n != 2 || !got || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL to_recover: cyc=%0d rdata=%h err=%b required 2 %h %b", cyc_n, rd, er, e.rdata, e.err); end
    endtask

    task automatic test_backpressure;
        exp_t e; bit bad; logic [31:0] rd; logic er;
        issue8(1'b0, 28'h0000030, 32'h0, 4'hF, 1'b1, 32'hCAFE_0042, 1'b0);
        bus_slave8(1, 32'hCAFE_0042);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if8.wb_ack_i = (i == 2);
            if8.wb_dat_i = 32'h1111_2222;
            if (if8.rsp_valid !== 1'b1 || if8.rsp_rdata !== 32'hCAFE_0042 || if8.rsp_err !== 1'b0 ||
                if8.cmd_ready !== 1'b0 || if8.wb_cyc_o !== 1'b0) bad = 1'b1;
        end
        if8.wb_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (bad || if8.rsp_rdata !== 32'hCAFE_0042 || if8.wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL bp_hold: rsp/cmd_ready/cyc disturbed, rdata=%h required cafe0042", if8.rsp_rdata); end
        rd = if8.rsp_rdata; er = if8.rsp_err;
        if8.rsp_ready = 1'b1;
        checks++; if (if8.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_turnaround: cmd_ready=%b during handshake required 0", if8.cmd_ready); end
        @(negedge clk);
        if8.rsp_ready = 1'b0;
        checks++; if (if8.cmd_ready !== 1'b1 || if8.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b required 1 0", if8.cmd_ready, if8.rsp_valid); end
        e = sb.pop_front();
        checks++; if (rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL bp_rsp: rdata=%h err=%b required %h %b", rd, er, e.rdata, e.err); end
        if8.wb_ack_i = 1'b1;
        @(negedge clk);
        if8.wb_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (if8.wb_cyc_o !== 1'b0 || if8.cmd_ready !== 1'b1 || if8.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ack: cyc=%b cmd_ready=%b rsp_valid=%b required 0 1 0",
                               if8.wb_cyc_o, if8.cmd_ready, if8.rsp_valid); end
    endtask

    task automatic test_reset_mid;
        bit bad;
        issue8(1'b0, 28'h0000040, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (if8.wb_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: cyc=%b required 1 in 2nd bus cycle", if8.wb_cyc_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if8.wb_cyc_o !== 1'b0 || if8.wb_stb_o !== 1'b0 || if8.rsp_valid !== 1'b0 || if8.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b required 0 0 0 1",
                               if8.wb_cyc_o, if8.wb_stb_o, if8.rsp_valid, if8.cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.rsp_valid !== 1'b0 || if8.wb_cyc_o !== 1'b0 || if8.cmd_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad || sb.size() != 0) begin
            errors++; $display("FAIL rst_mid_stale: stale activity after reset, queue=%0d required 0", sb.size()); end
    endtask

    task automatic test_ack_timeout_coincide;
        exp_t e; int n;
        for (int pass = 0; pass < 2; pass++) begin
            if4.cmd_we = 1'b0; if4.cmd_addr = 28'h0000050; if4.cmd_wdata = 32'h0; if4.cmd_sel = 4'hF;
            if4.wb_dat_i = 32'h7777_0000;
            if4.cmd_valid = 1'b1;
            e.rdata = (pass == 0) ? 32'h1234_5678 : 32'h0;
            e.err   = (pass == 0) ? 1'b0 : 1'b1;
            sb.push_back(e);
            @(negedge clk);
            if4.cmd_valid = 1'b0;
            n = 0;
            for (int i = 0; i < 20; i++) begin
                if (i > 0) @(negedge clk);
                if4.wb_ack_i = 1'b0;
                if (!if4.wb_cyc_o) break;
                n++;
                if (n == 4 && pass == 0) begin
                    if4.wb_ack_i = 1'b1;
                    if4.wb_dat_i = 32'h1234_5678;
                end
            end
            e = sb.pop_front();
            checks++; if (n != 4 || if4.rsp_valid !== 1'b1 || if4.rsp_rdata !== e.rdata || if4.rsp_err !== e.err) begin
                errors++; $display("FAIL t4_pass%0d: cyc=%0d valid=%b rdata=%h err=%b required 4 1 %h %b",
                                   pass, n, if4.rsp_valid, if4.rsp_rdata, if4.rsp_err, e.rdata, e.err); end
            if4.rsp_ready = 1'b1;
            @(negedge clk);
            if4.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        if8.cmd_valid = 1'b0; if8.cmd_we = 1'b0; if8.cmd_addr = '0; if8.cmd_wdata = '0; if8.cmd_sel = '0;
        if8.rsp_ready = 1'b0; if8.wb_dat_i = '0; if8.wb_ack_i = 1'b0;
        if4.cmd_valid = 1'b0; if4.cmd_we = 1'b0; if4.cmd_addr = '0; if4.cmd_wdata = '0; if4.cmd_sel = '0;
        if4.rsp_ready = 1'b0; if4.wb_dat_i = '0; if4.wb_ack_i = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_ack_timeout_coincide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
